// File: rtl/clause_scan_engine_if.sv
// Handshake and memory-port bundle between the propagation controller, the clause
// memory and clause_scan_engine.
interface clause_scan_engine_if #(
  parameter int NUM_CLAUSES           = 64,
  parameter int VAR_ID_BITS           = 8,
  parameter int NUM_CLAUSES_PER_CYCLE = 16,
  parameter int NUM_VARS_PER_CLAUSE   = 3
) ();
  localparam int NUM_CHUNKS = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE;
  localparam int ADDR_BITS  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int IDX_BITS   = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
  localparam int LIT_BITS   = VAR_ID_BITS + 1;
  localparam int DATA_BITS  = LIT_BITS * NUM_VARS_PER_CLAUSE * NUM_CLAUSES_PER_CYCLE;

  logic                   start;
  logic                   clear;
  logic [VAR_ID_BITS-1:0] assign_var_id;
  logic                   assign_var_val;
  logic                   mem_rd_en;
  logic [ADDR_BITS-1:0]   mem_rd_addr;
  logic [DATA_BITS-1:0]   mem_rd_data;
  logic                   busy;
  logic                   done;
  logic                   conflict;
  logic [IDX_BITS-1:0]    conflict_idx;
  logic                   unit_found;
  logic [IDX_BITS-1:0]    unit_idx;
  logic [NUM_CLAUSES-1:0] clause_sat;

  modport slave (
    input  start, clear, assign_var_id, assign_var_val, mem_rd_data,
    output mem_rd_en, mem_rd_addr, busy, done, conflict, conflict_idx,
           unit_found, unit_idx, clause_sat
  );

  modport master (
    output start, clear, assign_var_id, assign_var_val, mem_rd_data,
    input  mem_rd_en, mem_rd_addr, busy, done, conflict, conflict_idx,
           unit_found, unit_idx, clause_sat
  );
endinterface

// File: rtl/clause_scan_engine.sv
// Multi-cycle clause scanner: applies one variable assignment to every clause chunk,
// accumulates satisfied/falsified state, then reports lowest conflict and unit clauses.
module clause_scan_engine #(
  parameter int NUM_CLAUSES           = 64,
  parameter int VAR_ID_BITS           = 8,
  parameter int NUM_CLAUSES_PER_CYCLE = 16,
  parameter int NUM_VARS_PER_CLAUSE   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  clause_scan_engine_if.slave bus
);
  localparam int NCPC       = NUM_CLAUSES_PER_CYCLE;
  localparam int NVPC       = NUM_VARS_PER_CLAUSE;
  localparam int NUM_CHUNKS = NUM_CLAUSES / NCPC;
  localparam int ADDR_BITS  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int IDX_BITS   = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
  localparam int LIT_BITS   = VAR_ID_BITS + 1;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN, ST_FINISH} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   rd_en_q, rd_en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [VAR_ID_BITS-1:0] var_id_q, var_id_d;
  logic                   var_val_q, var_val_d;
  logic                   rd_pending_q;
  logic [ADDR_BITS-1:0]   rd_addr_dly_q;
  logic                   conflict_q, conflict_d;
  logic [IDX_BITS-1:0]    conflict_idx_q, conflict_idx_d;
  logic                   unit_q, unit_d;
  logic [IDX_BITS-1:0]    unit_idx_q, unit_idx_d;
  logic                   clear_state;

  // Clause state, chunk-major so the flat view lines up with clause index addr*NCPC+s.
  logic [NUM_CHUNKS-1:0][NCPC-1:0]           sat_q, sat_d;
  logic [NUM_CHUNKS-1:0][NCPC-1:0][NVPC-1:0] fals_q, fals_d;
  logic [NUM_CLAUSES-1:0]                    sat_flat;
  logic [NUM_CLAUSES-1:0][NVPC-1:0]          fals_flat;

  logic                enc_conf_hit, enc_unit_hit;
  logic [IDX_BITS-1:0] enc_conf_idx, enc_unit_idx;

  assign sat_flat  = sat_q;
  assign fals_flat = fals_q;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    rd_en_d        = 1'b0;
    done_d         = 1'b0;
    var_id_d       = var_id_q;
    var_val_d      = var_val_q;
    conflict_d     = conflict_q;
    conflict_idx_d = conflict_idx_q;
    unit_d         = unit_q;
    unit_idx_d     = unit_idx_q;
    clear_state    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.clear) begin
          clear_state = 1'b1;
        end else if (bus.start) begin
          var_id_d  = bus.assign_var_id;
          var_val_d = bus.assign_var_val;
          addr_d    = '0;
          rd_en_d   = 1'b1;
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (addr_q == LAST_ADDR) begin
          state_d = ST_DRAIN;
        end else begin
          addr_d  = addr_q + ADDR_BITS'(1);
          rd_en_d = 1'b1;
        end
      end
      ST_DRAIN: state_d = ST_FINISH;
      ST_FINISH: begin
        state_d        = ST_IDLE;
        done_d         = 1'b1;
        conflict_d     = enc_conf_hit;
        conflict_idx_d = enc_conf_idx;
        unit_d         = enc_unit_hit;
        unit_idx_d     = enc_unit_idx;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // A chunk returned one cycle after its read updates the clauses at the delayed address.
  always_comb begin
    sat_d  = sat_q;
    fals_d = fals_q;
    if (clear_state) begin
      sat_d  = '0;
      fals_d = '0;
    end else if (rd_pending_q) begin
      for (int s = 0; s < NCPC; s++) begin
        for (int j = 0; j < NVPC; j++) begin
          if (bus.mem_rd_data[(s*NVPC+j)*LIT_BITS +: VAR_ID_BITS] == var_id_q) begin
            if (bus.mem_rd_data[(s*NVPC+j)*LIT_BITS + VAR_ID_BITS] == var_val_q)
              fals_d[rd_addr_dly_q][s][j] = 1'b1;
            else
              sat_d[rd_addr_dly_q][s] = 1'b1;
          end
        end
      end
    end
  end

  // Walk downward so the lowest matching index is the last one written.
  always_comb begin
    enc_conf_hit = 1'b0;
    enc_conf_idx = '0;
    enc_unit_hit = 1'b0;
    enc_unit_idx = '0;
    for (int i = NUM_CLAUSES - 1; i >= 0; i--) begin
      if (!sat_flat[i]) begin
        if (&fals_flat[i]) begin
          enc_conf_hit = 1'b1;
          enc_conf_idx = IDX_BITS'(i);
        end
        if ($countones(fals_flat[i]) == NVPC - 1) begin
          enc_unit_hit = 1'b1;
          enc_unit_idx = IDX_BITS'(i);
        end
      end
    end
  end

  // NOTE: state uses non-blocking assignments; clause state lives in flops, so the
  // asynchronous reset clears it along with the control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      rd_en_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      var_id_q       <= '0;
      var_val_q      <= 1'b0;
      rd_pending_q   <= 1'b0;
      rd_addr_dly_q  <= '0;
      conflict_q     <= 1'b0;
      conflict_idx_q <= '0;
      unit_q         <= 1'b0;
      unit_idx_q     <= '0;
      sat_q          <= '0;
      fals_q         <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      rd_en_q        <= rd_en_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      var_id_q       <= var_id_d;
      var_val_q      <= var_val_d;
      rd_pending_q   <= rd_en_q;
      rd_addr_dly_q  <= addr_q;
      conflict_q     <= conflict_d;
      conflict_idx_q <= conflict_idx_d;
      unit_q         <= unit_d;
      unit_idx_q     <= unit_idx_d;
      sat_q          <= sat_d;
      fals_q         <= fals_d;
    end
  end

  assign bus.mem_rd_en    = rd_en_q;
  assign bus.mem_rd_addr  = addr_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.conflict     = conflict_q;
  assign bus.conflict_idx = conflict_idx_q;
  assign bus.unit_found   = unit_q;
  assign bus.unit_idx     = unit_idx_q;
  assign bus.clause_sat   = sat_flat;
endmodule
